// File: rtl/sid_write_sched.sv
// sid_write_sched: timed register-write scheduler for the sid_voices bus.
// The host pushes {addr, data, delay} entries into a FIFO. Each entry is replayed
// as a single-cycle write on a clkEn tick. After the write, the scheduler waits
// 'delay' further unpaused ticks before it issues the next entry.
// Ports:
//   clk, iRst        clock; synchronous active-high reset
//   clkEn            1MHz tick, one clk wide
//   iValid/oReady    host push handshake (oReady = !full && !iFlush)
//   iAddr/iData/iDelay  entry fields
//   iPause           freezes issue and the WAIT countdown
//   iFlush           drops queued entries and aborts WAIT
//   oWE/oAddr/oData  registered write bus to sid_voices
//   oLevel           FIFO occupancy, 0..2**DEPTH_LOG2
//   oBusy            FSM not idle or FIFO not empty
module sid_write_sched #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic                clkEn,
  input  logic                iValid,
  output logic                oReady,
  input  logic [4:0]          iAddr,
  input  logic [7:0]          iData,
  input  logic [15:0]         iDelay,
  input  logic                iPause,
  input  logic                iFlush,
  output logic                oWE,
  output logic [4:0]          oAddr,
  output logic [7:0]          oData,
  output logic [DEPTH_LOG2:0] oLevel,
  output logic                oBusy
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state, stateNext;
  logic [28:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2:0]   level;
  logic [15:0]           cnt, cntNext;
  logic                  empty, full, push, pop;
  logic [28:0]           head;

  assign empty  = (level == '0);
  assign full   = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign oReady = !full && !iFlush;
  assign push   = iValid && oReady;
  assign head   = mem[rdPtr];
  assign oLevel = level;
  assign oBusy  = (state != IDLE) || !empty;

  // Next-state logic. The FIFO level is registered, so an entry that is pushed
  // this cycle cannot be popped until the next cycle.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pop       = 1'b0;
    if (iFlush) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clkEn && !empty && !iPause) begin
            pop       = 1'b1;
            cntNext   = head[15:0];
            stateNext = (head[15:0] != '0) ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (clkEn && !iPause) begin
            cntNext = cnt - 16'd1;
            if (cnt == 16'd1) stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state <= IDLE;
      cnt   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      oWE   <= 1'b0;
      oAddr <= '0;
      oData <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      oWE   <= pop;
      if (pop) begin
        oAddr <= head[28:24];
        oData <= head[23:16];
      end
      if (iFlush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + DEPTH_LOG2'(1);
        if (pop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
        if (push && !pop)      level <= level + (DEPTH_LOG2 + 1)'(1);
        else if (pop && !push) level <= level - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  // Storage is not reset. Only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= {iAddr, iData, iDelay};
  end

endmodule
